usb_rx: RTL and testbench
=========================

# usb_rx

USB full-speed receive path: the inbound counterpart of the transmit pipeline in the same USB endpoint. It samples the D+/D- line pair, then:
- performs NRZI decode and bit unstuffing,
- detects SYNC/PID/EOP,
- writes data-packet payload bytes into the shared endpoint FIFO,
- reports the decoded packet type to the AHB-side controller.

## Interface
Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit period; even, ≥4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Dplus_in  in  1  raw D+ line, asynchronous to clk.
- Dminus_in  in  1  raw D- line, asynchronous to clk.
- buffer_occupancy  in  7  current FIFO byte count, 0..64.
- rx_packet  out  4  decoded PID code:
  - 0 = none
  - 1 = OUT
  - 2 = IN
  - 3 = DATA0
  - 4 = DATA1
  - 5 = ACK
  - 6 = NAK
  - 7 = STALL
- rx_data_ready  out  1  one-cycle pulse; the packet completed without error.
- rx_transfer_active  out  1  a packet is in progress on the bus.
- rx_error  out  1  the last packet was aborted.
- flush_buffer  out  1  one-cycle pulse; the FIFO must be cleared before a DATA payload.
- store_rx_packet_data  out  1  one-cycle write strobe.
- rx_packet_data  out  8  byte to write; valid while the strobe is high.

## Operation
- Input synchronisation:
  - Dplus_in/Dminus_in pass through 2-flop synchronisers.
  - Line states: J = (1,0), K = (0,1), SE0 = (0,0).
- Bit recovery:
  - A bit counter restarts on every synchronised D+ transition.
  - Each bit is sampled at count CLKS_PER_BIT/2.
  - NRZI decode: no change from the previous sample = 1, change = 0.
- Unstuffing: after six consecutive decoded 1s, the next bit must be 0 and is discarded. A 1 in that position is a stuff error.
- Bytes are assembled LSB first.
- State machine:
  - IDLE: first K sets rx_transfer_active=1 and clears rx_error and rx_packet → SYNC.
  - SYNC: the decoded byte must equal 0x80, else → ERR.
  - PID: the low nibble must equal the bitwise complement of the high nibble, and the nibble must be a supported PID, else → ERR.
    - Supported PID bytes: OUT 0xE1, IN 0x69, DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
    - Handshake PIDs → EOP.
    - OUT/IN → TOKEN.
    - DATA0/DATA1 → DATA, with flush_buffer pulsed once.
  - TOKEN: receive 2 bytes and discard them → EOP.
  - DATA: payload with a 2-byte holdback.
    - Each newly completed byte pushes the byte two positions older to the FIFO, so the final 2 bytes (CRC16) are never stored.
    - SE0 at a byte boundary → DONE.
  - EOP: SE0 must be seen for ≥1 sampled bit followed by J, else → ERR.
  - DONE:
    - Latch rx_packet and pulse rx_data_ready.
    - rx_transfer_active=0.
    - → IDLE.
  - ERR:
    - rx_error=1, rx_packet=0, no ready pulse.
    - Wait until the bus is idle (J held for 8 bit times) → IDLE.
- Error conditions, all → ERR:
  - stuff error;
  - SE0 mid-byte;
  - fewer than 2 bytes in DATA;
  - a byte arriving in EOP state;
  - overflow: a store is due while buffer_occupancy==64; that byte is not stored.
- rx_packet, rx_error: held until the next packet start.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - synchroniser flops hold J (1,0).
- Reset mid-packet: immediate return to IDLE. No strobe or pulse is emitted during or after reset until a new SYNC arrives.
- Synchroniser latency: 2 cycles.
- Store timing: store_rx_packet_data asserts exactly 1 cycle, on the cycle after the 3rd-newer byte's final bit is sampled. At most one store per byte period.
- flush_buffer: the cycle after the PID byte is accepted; always ≥1 byte period before the first store.
- rx_data_ready: exactly 1 cycle, on the cycle following EOP J detection. rx_transfer_active falls on the same cycle.
- Simultaneous error and pending store: the error wins; the store is suppressed.

## Configuration
- USB_RX_CRC16_EN defined:
  - CRC16 (poly 0x8005, init 0xFFFF) runs over payload+CRC bytes.
  - The residual must equal 0x800D at EOP, else ERR instead of DONE.
  - Bytes already stored remain in the FIFO; the controller discards them on rx_error.
- Undefined: no CRC logic; CRC bytes are still withheld from the FIFO; DATA packets complete on a valid EOP alone.

## Test plan
- ACK: SYNC, 0xD2, EOP →
  - rx_packet=5;
  - one rx_data_ready pulse;
  - no store and no flush strobe;
  - rx_transfer_active 1→0.
- DATA0 with payload 0x01 0x02 0x03 + valid CRC →
  - one flush pulse;
  - 3 stores in order 0x01, 0x02, 0x03;
  - rx_packet=3, ready pulse.
- DATA1 with payload 0xFF 0xFF (stuffed 0s on line) → stores 0xFF, 0xFF. The same packet with a stuffed 0 replaced by 1 → rx_error=1, rx_packet=0.
- Bad PID byte 0xD3 → rx_error=1, no flush, no ready. The next valid ACK clears rx_error and reports 5.
- DATA0 with buffer_occupancy=64 → no store, rx_error=1. With the macro: a corrupted CRC byte → rx_error=1, no ready.
- rst asserted mid-payload → all outputs 0 immediately. A following IN token → rx_packet=2, ready pulse.

Source files
------------

// File: rtl/usb_rx.sv
// usb_rx: USB full-speed receive path (sync, NRZI decode, unstuffing, SYNC/PID/EOP, FIFO writes).
// Optional feature: define USB_RX_CRC16_EN to check the DATA-packet CRC16 residual at EOP.
module usb_rx #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Dplus_in,
  input  logic       Dminus_in,
  input  logic [6:0] buffer_occupancy,
  output logic [3:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       flush_buffer,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data
);
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOP, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic          dp_s1, dp_s2, dm_s1, dm_s2, dp_d, last_dp;
  logic [CW-1:0] cnt;
  logic [2:0]    ones;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic [7:0]    hold0, hold1;
  logic [1:0]    nbytes;
  logic [3:0]    pid_code;
  logic          se0_seen;
  logic [2:0]    j_cnt;

  logic       samp, line_j, line_k, line_se0, nrzi_bit, stuff_bit, pkt_ok;
  logic [7:0] new_byte;

  assign samp      = (cnt == CW'(HALF));
  assign line_j    = dp_s2 & ~dm_s2;
  assign line_k    = ~dp_s2 & dm_s2;
  assign line_se0  = ~dp_s2 & ~dm_s2;
  assign nrzi_bit  = (dp_s2 == last_dp);
  assign stuff_bit = (ones == 3'd6);
  assign new_byte  = {nrzi_bit, shreg};

`ifdef USB_RX_CRC16_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction

  assign pkt_ok = !((pid_code == 4'd3) || (pid_code == 4'd4)) || (crc == 16'h800D);
`else
  assign pkt_ok = 1'b1;
`endif

  function automatic logic [3:0] pid_decode(input logic [7:0] b);
    case (b)
      8'hE1:   return 4'd1;
      8'h69:   return 4'd2;
      8'hC3:   return 4'd3;
      8'h4B:   return 4'd4;
      8'hD2:   return 4'd5;
      8'h5A:   return 4'd6;
      8'h1E:   return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1 <= 1'b1; dp_s2 <= 1'b1; dp_d <= 1'b1; last_dp <= 1'b1;
      dm_s1 <= 1'b0; dm_s2 <= 1'b0;
      cnt <= '0; ones <= '0; bit_cnt <= '0; shreg <= '0;
      hold0 <= '0; hold1 <= '0; nbytes <= '0; pid_code <= '0;
      se0_seen <= 1'b0; j_cnt <= '0;
      state <= S_IDLE;
      rx_packet <= '0; rx_data_ready <= 1'b0; rx_transfer_active <= 1'b0;
      rx_error <= 1'b0; flush_buffer <= 1'b0; store_rx_packet_data <= 1'b0;
      rx_packet_data <= '0;
`ifdef USB_RX_CRC16_EN
      crc <= '1;
`endif
    end else begin
      dp_s1 <= Dplus_in;  dp_s2 <= dp_s1;
      dm_s1 <= Dminus_in; dm_s2 <= dm_s1;
      dp_d  <= dp_s2;
      // Bit clock re-phases on every D+ edge so the sample stays mid-bit.
      cnt <= ((dp_s2 != dp_d) || (cnt == CW'(CLKS_PER_BIT - 1))) ? '0 : cnt + 1'b1;
      if (samp && !line_se0) last_dp <= dp_s2;

      rx_data_ready        <= 1'b0;
      flush_buffer         <= 1'b0;
      store_rx_packet_data <= 1'b0;

      case (state)
        S_IDLE: if (samp && line_k) begin
          rx_transfer_active <= 1'b1;
          rx_error  <= 1'b0;
          rx_packet <= '0;
          shreg     <= new_byte[7:1];
          bit_cnt   <= 3'd1;
          ones      <= '0;
          j_cnt     <= '0;
          state     <= S_SYNC;
        end

        S_SYNC, S_PID, S_TOKEN, S_DATA: if (samp) begin
          if (line_se0) begin
            if (state == S_DATA && bit_cnt == 3'd0 && nbytes == 2'd2) begin
              se0_seen <= 1'b1;
              state    <= S_EOP;
            end else begin
              state <= S_ERR;
            end
          end else if (stuff_bit) begin
            if (nrzi_bit) state <= S_ERR;
            else          ones  <= '0;
          end else begin
            ones    <= nrzi_bit ? ones + 3'd1 : '0;
            shreg   <= new_byte[7:1];
            bit_cnt <= bit_cnt + 3'd1;
`ifdef USB_RX_CRC16_EN
            if (state == S_DATA) crc <= crc_step(crc, nrzi_bit);
`endif
            if (bit_cnt == 3'd7) begin
              case (state)
                S_SYNC: state <= (new_byte == 8'h80) ? S_PID : S_ERR;
                S_PID: begin
                  pid_code <= pid_decode(new_byte);
                  nbytes   <= '0;
                  se0_seen <= 1'b0;
                  case (pid_decode(new_byte))
                    4'd1, 4'd2: state <= S_TOKEN;
                    4'd3, 4'd4: begin
                      state        <= S_DATA;
                      flush_buffer <= 1'b1;
`ifdef USB_RX_CRC16_EN
                      crc          <= '1;
`endif
                    end
                    4'd5, 4'd6, 4'd7: state <= S_EOP;
                    default:          state <= S_ERR;
                  endcase
                end
                S_TOKEN: begin
                  if (nbytes == 2'd1) state <= S_EOP;
                  else                nbytes <= 2'd1;
                end
                default: begin
                  // Two-byte holdback: the byte leaving hold1 is never part of the CRC.
                  hold0 <= new_byte;
                  hold1 <= hold0;
                  if (nbytes == 2'd2) begin
                    if (buffer_occupancy == 7'd64) begin
                      state <= S_ERR;
                    end else begin
                      store_rx_packet_data <= 1'b1;
                      rx_packet_data       <= hold1;
                    end
                  end else begin
                    nbytes <= nbytes + 2'd1;
                  end
                end
              endcase
            end
          end
        end

        S_EOP: if (samp) begin
          if (line_se0) begin
            se0_seen <= 1'b1;
          end else if (!se0_seen && stuff_bit && !nrzi_bit) begin
            ones <= '0;
          end else if (se0_seen && line_j && pkt_ok) begin
            rx_packet          <= pid_code;
            rx_data_ready      <= 1'b1;
            rx_transfer_active <= 1'b0;
            state              <= S_DONE;
          end else begin
            state <= S_ERR;
          end
        end

        S_DONE: state <= S_IDLE;

        default: begin
          rx_error           <= 1'b1;
          rx_packet          <= '0;
          rx_transfer_active <= 1'b0;
          if (samp) begin
            if (!line_j)               j_cnt <= '0;
            else if (j_cnt == 3'd7)    state <= S_IDLE;
            else                       j_cnt <= j_cnt + 3'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: drives bit-stuffed NRZI packets into usb_rx and compares FIFO writes and
// status against a byte-level packet model built in the bench.
`timescale 1ns/1ps
module tb_usb_rx;
  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dp  = 1'b1;
  logic       dm  = 1'b0;
  logic [6:0] occ = '0;
  logic [3:0] rx_packet;
  logic       rx_data_ready, rx_transfer_active, rx_error, flush_buffer, store_rx_packet_data;
  logic [7:0] rx_packet_data;

  usb_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .Dplus_in             (dp),
    .Dminus_in            (dm),
    .buffer_occupancy     (occ),
    .rx_packet            (rx_packet),
    .rx_data_ready        (rx_data_ready),
    .rx_transfer_active   (rx_transfer_active),
    .rx_error             (rx_error),
    .flush_buffer         (flush_buffer),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitor: written only here.
  longint     cyc = 0;
  int         store_cnt = 0, flush_cnt = 0, ready_cnt = 0, act_cnt = 0;
  longint     flush_cyc = 0;
  logic [7:0] got_q[$];
  longint     got_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (store_rx_packet_data) begin
      store_cnt++;
      got_q.push_back(rx_packet_data);
      got_cyc.push_back(cyc);
    end
    if (flush_buffer) begin
      flush_cnt++;
      flush_cyc = cyc;
    end
    if (rx_data_ready) ready_cnt++;
    if (rx_transfer_active) act_cnt++;
  end

  // Stimulus/model state: written only by the initial block and its tasks.
  int         s0, f0, r0, a0;
  logic [7:0] pay[$];
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({rx_packet, rx_data_ready, rx_transfer_active, rx_error,
                flush_buffer, store_rx_packet_data, rx_packet_data});
  endfunction

  task automatic snap();
    s0 = store_cnt; f0 = flush_cnt; r0 = ready_cnt; a0 = act_cnt;
  endtask

  task automatic sym(input logic p, input logic m);
    dp = p; dm = m;
    repeat (CPB) @(negedge clk);
  endtask

  // Packet bytes: SYNC, PID, payload, and optionally CRC16 (complemented, MSB of register first).
  task automatic build(input logic [7:0] pid, input bit with_crc, input bit bad_crc);
    logic [15:0] c;
    logic        fb;
    logic [7:0]  b0, b1;
    pkt.delete();
    pkt.push_back(8'h80);
    pkt.push_back(pid);
    foreach (pay[i]) pkt.push_back(pay[i]);
    if (with_crc) begin
      c = 16'hFFFF;
      foreach (pay[i])
        for (int k = 0; k < 8; k++) begin
          fb = pay[i][k] ^ c[15];
          c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
      for (int k = 0; k < 8; k++) begin
        b0[k] = ~c[15-k];
        b1[k] = ~c[7-k];
      end
      if (bad_crc) b1 = b1 ^ 8'h40;
      pkt.push_back(b0);
      pkt.push_back(b1);
    end
  endtask

  // Bit-stuff, NRZI-encode and drive pkt, then EOP and idle; stop_sym>=0 aborts early.
  task automatic drive(input bit bad_stuff, input int stop_sym);
    bit   bits[$];
    int   ones, n;
    bit   corrupted, sb;
    logic lvl;
    ones = 0; corrupted = 0;
    foreach (pkt[i])
      for (int k = 0; k < 8; k++) begin
        bits.push_back(pkt[i][k]);
        ones = pkt[i][k] ? ones + 1 : 0;
        if (ones == 6) begin
          sb = bad_stuff && !corrupted;
          bits.push_back(sb);
          if (sb) corrupted = 1;
          ones = 0;
        end
      end
    lvl = 1'b1; n = 0;
    foreach (bits[j]) begin
      if (stop_sym >= 0 && n >= stop_sym) return;
      if (!bits[j]) lvl = ~lvl;
      sym(lvl, ~lvl);
      n++;
    end
    sym(1'b0, 1'b0);
    sym(1'b0, 1'b0);
    repeat (12) sym(1'b1, 1'b0);
  endtask

  task automatic verify(input string tag, input int code, input bit err, input int flushes);
    chk({tag, "_ready"},  32'(ready_cnt - r0), err ? 32'd0 : 32'd1);
    chk({tag, "_pid"},    32'(rx_packet), 32'(code));
    chk({tag, "_err"},    32'(rx_error), 32'(err));
    chk({tag, "_flush"},  32'(flush_cnt - f0), 32'(flushes));
    chk({tag, "_nstore"}, 32'(store_cnt - s0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && s0 + i < store_cnt; i++)
      chk({tag, "_byte"}, 32'(got_q[s0+i]), 32'(exp_q[i]));
    chk({tag, "_active_seen"}, 32'(act_cnt > a0), 32'd1);
    chk({tag, "_active_end"},  32'(rx_transfer_active), 32'd0);
  endtask

  initial begin
    int   n;
    logic [7:0] pidb;
    int   code;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) sym(1'b1, 1'b0);
    chk("idle_outputs", outs(), 32'd0);

    // ACK handshake
    pay.delete(); exp_q.delete();
    build(8'hD2, 0, 0); snap(); drive(0, -1);
    verify("ack", 5, 0, 0);

    // DATA0 01 02 03
    pay = '{8'h01, 8'h02, 8'h03}; exp_q = pay;
    build(8'hC3, 1, 0); snap(); drive(0, -1);
    verify("data0", 3, 0, 1);
    if (store_cnt > s0)
      chk("flush_lead", 32'((got_cyc[s0] - flush_cyc) >= longint'(8 * CPB)), 32'd1);

    // DATA1 FF FF (stuffed line), then same with a stuffed 0 replaced by 1
    pay = '{8'hFF, 8'hFF}; exp_q = pay;
    build(8'h4B, 1, 0); snap(); drive(0, -1);
    verify("data1_ff", 4, 0, 1);
    exp_q.delete();
    snap(); drive(1, -1);
    verify("stuff_err", 0, 1, 1);

    // Bad PID, then ACK clears the error
    pay.delete(); exp_q.delete();
    build(8'hD3, 0, 0); snap(); drive(0, -1);
    verify("bad_pid", 0, 1, 0);
    build(8'hD2, 0, 0); snap(); drive(0, -1);
    verify("ack_after_err", 5, 0, 0);

    // Randomised DATA packets
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(0, 5);
      pay.delete();
      for (int i = 0; i < n; i++)
        pay.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      exp_q = pay;
      pidb = ($urandom_range(0, 1) == 0) ? 8'hC3 : 8'h4B;
      code = (pidb == 8'hC3) ? 3 : 4;
      build(pidb, 1, 0); snap(); drive(0, -1);
      verify("rand_data", code, 0, 1);
    end

    // Occupancy boundary: 63 still stores, 64 overflows
    occ = 7'd63;
    pay = '{8'hA5, 8'h5A, 8'h3C}; exp_q = pay;
    build(8'hC3, 1, 0); snap(); drive(0, -1);
    verify("occ63", 3, 0, 1);
    occ = 7'd64; exp_q.delete();
    snap(); drive(0, -1);
    verify("overflow", 0, 1, 1);
    occ = 7'd0;

`ifdef USB_RX_CRC16_EN
    pay = '{8'h11, 8'h22, 8'h33}; exp_q = pay;
    build(8'hC3, 1, 1); snap(); drive(0, -1);
    verify("bad_crc", 0, 1, 1);
`endif

    // Reset mid-payload, then an IN token
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    build(8'hC3, 1, 0); snap(); drive(0, 52);
    chk("pre_reset_stores", 32'(store_cnt - s0), 32'd2);
    rst = 1'b1; dp = 1'b1; dm = 1'b0;
    #1;
    chk("rst_mid_outputs", outs(), 32'd0);
    snap();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) sym(1'b1, 1'b0);
    chk("rst_no_strobe", 32'((store_cnt - s0) + (flush_cnt - f0) + (ready_cnt - r0)), 32'd0);
    chk("rst_after_outputs", outs(), 32'd0);
    pay = '{8'($urandom), 8'($urandom)}; exp_q.delete();
    build(8'h69, 0, 0); snap(); drive(0, -1);
    verify("in_token", 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
